iq_entry_decoder: RTL and testbench

IQ_ENTRY_DECODER -- requirements
Module: iq_entry_decoder

---
 rtl/iq_entry_decoder_pkg.sv | 12 +
 rtl/iq_entry_decoder_index_decoder.sv | 27 ++
 rtl/iq_entry_decoder.sv | 124 ++++++++++++
 tb/tb_iq_entry_decoder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_entry_decoder_pkg.sv
// Shared core configuration for the issue-queue occupancy tracker.
// Holds the issue-queue size and the dispatch/issue widths. Modules take
// their parameter defaults from here, so every block agrees on the same core
// shape.
package iq_entry_decoder_pkg;

  localparam int IQ_DEPTH       = 32;  // issue-queue entries
  localparam int IQ_DEPTH_LOG   = 5;   // log2(IQ_DEPTH)
  localparam int DISPATCH_WIDTH = 4;   // allocate ports
  localparam int ISSUE_WIDTH    = 4;   // release ports

endpackage

// File: rtl/iq_entry_decoder_index_decoder.sv
// IndexDecoder: combinational index-to-one-hot decoder with an enable.
// Ports:
//   en     in  1          strobe for this port
//   idx    in  DEPTH_LOG  entry index
//   onehot out DEPTH      one-hot of idx; all zero when en is low or idx >= DEPTH
//   oob    out 1          en is high and idx is outside the populated entries
module IndexDecoder
  import iq_entry_decoder_pkg::*;
#(
  parameter int DEPTH     = IQ_DEPTH,
  parameter int DEPTH_LOG = IQ_DEPTH_LOG
) (
  input  logic                 en,
  input  logic [DEPTH_LOG-1:0] idx,
  output logic [DEPTH-1:0]     onehot,
  output logic                 oob
);

  logic in_range;

  // Zero-extend before comparing so that a non-power-of-two DEPTH still
  // rejects the indices that do not correspond to an entry.
  assign in_range = {{(32-DEPTH_LOG){1'b0}}, idx} < DEPTH;
  assign onehot   = (en && in_range) ? (DEPTH'(1) << idx) : '0;
  assign oob      = en && !in_range;

endmodule

// File: rtl/iq_entry_decoder.sv
// iq_entry_decoder: occupancy bitmap for the issue queue.
// Dispatch ports set entries and issue ports clear them. If an entry is set
// and cleared in the same cycle, the set wins. flush_i empties the queue.
// Any protocol violation raises error_o, and error_o stays high until reset.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   flush_i            squash: empty the queue, ignore this cycle's strobes
//   allocValid_i/Idx_i per-port allocate strobe and entry index (flat packed)
//   freeValid_i/Idx_i  per-port release strobe and entry index (flat packed)
//   validVector_o      registered occupancy bitmap
//   allocMask_o        registered OR of last cycle's allocations (one cycle)
//   count_o            registered popcount of validVector_o
//   full_o, empty_o    derived from count_o
//   error_o            sticky protocol-violation flag
module iq_entry_decoder
  import iq_entry_decoder_pkg::*;
#(
  parameter int DEPTH       = IQ_DEPTH,
  parameter int DEPTH_LOG   = IQ_DEPTH_LOG,
  parameter int ALLOC_WIDTH = DISPATCH_WIDTH,
  parameter int FREE_WIDTH  = ISSUE_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush_i,
  input  logic [ALLOC_WIDTH-1:0]         allocValid_i,
  input  logic [ALLOC_WIDTH*DEPTH_LOG-1:0] allocIdx_i,
  input  logic [FREE_WIDTH-1:0]          freeValid_i,
  input  logic [FREE_WIDTH*DEPTH_LOG-1:0]  freeIdx_i,
  output logic [DEPTH-1:0]               validVector_o,
  output logic [DEPTH-1:0]               allocMask_o,
  output logic [DEPTH_LOG:0]             count_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic                           error_o
);

  logic [ALLOC_WIDTH-1:0][DEPTH-1:0] alloc_oh;
  logic [FREE_WIDTH-1:0][DEPTH-1:0]  free_oh;
  logic [ALLOC_WIDTH-1:0]            alloc_oob;
  logic [FREE_WIDTH-1:0]             free_oob;

  for (genvar p = 0; p < ALLOC_WIDTH; p++) begin : g_alloc_dec
    IndexDecoder #(.DEPTH(DEPTH), .DEPTH_LOG(DEPTH_LOG)) u_dec (
      .en     (allocValid_i[p]),
      .idx    (allocIdx_i[p*DEPTH_LOG +: DEPTH_LOG]),
      .onehot (alloc_oh[p]),
      .oob    (alloc_oob[p])
    );
  end

  for (genvar p = 0; p < FREE_WIDTH; p++) begin : g_free_dec
    IndexDecoder #(.DEPTH(DEPTH), .DEPTH_LOG(DEPTH_LOG)) u_dec (
      .en     (freeValid_i[p]),
      .idx    (freeIdx_i[p*DEPTH_LOG +: DEPTH_LOG]),
      .onehot (free_oh[p]),
      .oob    (free_oob[p])
    );
  end

  logic [DEPTH-1:0]   alloc_set;
  logic [DEPTH-1:0]   free_clr;
  logic               alloc_dup;
  logic               free_dup;
  logic [DEPTH-1:0]   occ_next;
  logic [DEPTH_LOG:0] count_next;
  logic               violation;

  always_comb begin
    alloc_set = '0;
    alloc_dup = 1'b0;
    // A port whose one-hot overlaps the bits already collected from earlier
    // ports is carrying the same index as one of those ports.
    for (int p = 0; p < ALLOC_WIDTH; p++) begin
      alloc_dup = alloc_dup | (|(alloc_set & alloc_oh[p]));
      alloc_set = alloc_set | alloc_oh[p];
    end

    free_clr = '0;
    free_dup = 1'b0;
    for (int p = 0; p < FREE_WIDTH; p++) begin
      free_dup = free_dup | (|(free_clr & free_oh[p]));
      free_clr = free_clr | free_oh[p];
    end

    occ_next = (validVector_o & ~free_clr) | alloc_set;

    count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_next = count_next + (DEPTH_LOG+1)'(occ_next[i]);
    end

    // Allocating and releasing the same entry in one cycle is legal. Only an
    // allocation into an entry that stays occupied is a violation.
    violation = (|(alloc_set & validVector_o & ~free_clr))
              | (|(free_clr & ~validVector_o))
              | alloc_dup | free_dup
              | (|alloc_oob) | (|free_oob);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      validVector_o <= '0;
      allocMask_o   <= '0;
      count_o       <= '0;
      error_o       <= 1'b0;
    end else if (flush_i) begin
      // Strobes are ignored for the whole flush cycle, including their error
      // checks. A flush leaves error_o unchanged.
      validVector_o <= '0;
      allocMask_o   <= '0;
      count_o       <= '0;
    end else begin
      validVector_o <= occ_next;
      allocMask_o   <= alloc_set;
      count_o       <= count_next;
      if (violation) error_o <= 1'b1;
    end
  end

  assign full_o  = (count_o == (DEPTH_LOG+1)'(DEPTH));
  assign empty_o = (count_o == '0);

endmodule

// File: tb/tb_iq_entry_decoder.sv
module tb_iq_entry_decoder;

  localparam int D  = 32;
  localparam int DL = 5;
  localparam int AW = 4;
  localparam int FW = 4;

  logic            clk;
  logic            reset;
  logic            flush_i;
  logic [AW-1:0]   allocValid_i;
  logic [AW*DL-1:0] allocIdx_i;
  logic [FW-1:0]   freeValid_i;
  logic [FW*DL-1:0] freeIdx_i;
  logic [D-1:0]    validVector_o;
  logic [D-1:0]    allocMask_o;
  logic [DL:0]     count_o;
  logic            full_o;
  logic            empty_o;
  logic            error_o;

  iq_entry_decoder dut (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (flush_i),
    .allocValid_i  (allocValid_i),
    .allocIdx_i    (allocIdx_i),
    .freeValid_i   (freeValid_i),
    .freeIdx_i     (freeIdx_i),
    .validVector_o (validVector_o),
    .allocMask_o   (allocMask_o),
    .count_o       (count_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .error_o       (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // stimulus for the next cycle, cleared after every step
  bit a_v[AW];
  int a_i[AW];
  bit f_v[FW];
  int f_i[FW];

  // reference model: per-entry occupancy, last allocation mask, sticky error
  bit m_occ[D];
  bit m_mask[D];
  bit m_err;

  function automatic logic [D-1:0] m_vec();
    logic [D-1:0] v = '0;
    for (int e = 0; e < D; e++) v[e] = m_occ[e];
    return v;
  endfunction

  function automatic logic [D-1:0] m_mvec();
    logic [D-1:0] v = '0;
    for (int e = 0; e < D; e++) v[e] = m_mask[e];
    return v;
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int e = 0; e < D; e++) c += int'(m_occ[e]);
    return c;
  endfunction

  // Apply one clock cycle and advance the model from the rules: count how many
  // ports name each entry, then decide occupancy and violations per entry.
  task automatic step(input bit rst, input bit fl);
    int  ac[D];
    int  fc[D];
    bit  nocc[D];
    bit  viol;
    reset   = rst;
    flush_i = fl;
    for (int p = 0; p < AW; p++) begin
      allocValid_i[p] = a_v[p];
      allocIdx_i[p*DL +: DL] = DL'(a_i[p]);
    end
    for (int p = 0; p < FW; p++) begin
      freeValid_i[p] = f_v[p];
      freeIdx_i[p*DL +: DL] = DL'(f_i[p]);
    end
    viol = 1'b0;
    for (int e = 0; e < D; e++) begin ac[e] = 0; fc[e] = 0; end
    for (int p = 0; p < AW; p++)
      if (a_v[p]) begin
        if (a_i[p] >= D) viol = 1'b1; else ac[a_i[p]]++;
      end
    for (int p = 0; p < FW; p++)
      if (f_v[p]) begin
        if (f_i[p] >= D) viol = 1'b1; else fc[f_i[p]]++;
      end
    for (int e = 0; e < D; e++) begin
      nocc[e] = (ac[e] > 0) || (m_occ[e] && fc[e] == 0);
      if (ac[e] > 1 || fc[e] > 1) viol = 1'b1;
      if (ac[e] > 0 && m_occ[e] && fc[e] == 0) viol = 1'b1;
      if (fc[e] > 0 && !m_occ[e]) viol = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int e = 0; e < D; e++) begin
      if (rst || fl) begin
        m_occ[e] = 1'b0; m_mask[e] = 1'b0;
      end else begin
        m_occ[e] = nocc[e]; m_mask[e] = (ac[e] > 0);
      end
    end
    if (rst) m_err = 1'b0;
    else if (!fl && viol) m_err = 1'b1;
    for (int p = 0; p < AW; p++) begin a_v[p] = 1'b0; a_i[p] = 0; end
    for (int p = 0; p < FW; p++) begin f_v[p] = 1'b0; f_i[p] = 0; end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0);
    n_chk++; if (validVector_o !== '0) begin n_err++; $display("FAIL reset_valid got=%h exp=0", validVector_o); end
    n_chk++; if (allocMask_o !== '0) begin n_err++; $display("FAIL reset_mask got=%h exp=0", allocMask_o); end
    n_chk++; if (count_o !== '0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    n_chk++; if (empty_o !== 1'b1 || full_o !== 1'b0) begin n_err++; $display("FAIL reset_flags empty=%b full=%b exp empty=1 full=0", empty_o, full_o); end
    n_chk++; if (error_o !== 1'b0) begin n_err++; $display("FAIL reset_error got=%b exp=0", error_o); end
  endtask

  task automatic test_alloc_basic();
    step(1'b1, 1'b0);
    a_v = '{1, 1, 1, 1}; a_i = '{0, 5, 31, 7};
    step(1'b0, 1'b0);
    n_chk++; if (validVector_o !== 32'h800000A1) begin n_err++; $display("FAIL alloc_valid got=%h exp=800000a1", validVector_o); end
    n_chk++; if (allocMask_o !== 32'h800000A1) begin n_err++; $display("FAIL alloc_mask got=%h exp=800000a1", allocMask_o); end
    n_chk++; if (count_o !== 6'd4) begin n_err++; $display("FAIL alloc_count got=%0d exp=4", count_o); end
    step(1'b0, 1'b0);
    n_chk++; if (allocMask_o !== '0) begin n_err++; $display("FAIL alloc_mask_hold got=%h exp=0", allocMask_o); end
    n_chk++; if (validVector_o !== 32'h800000A1) begin n_err++; $display("FAIL alloc_valid_hold got=%h exp=800000a1", validVector_o); end
  endtask

  task automatic test_alloc_free_same();
    step(1'b1, 1'b0);
    a_v[0] = 1; a_i[0] = 5;
    step(1'b0, 1'b0);
    a_v[1] = 1; a_i[1] = 5; f_v[2] = 1; f_i[2] = 5;
    step(1'b0, 1'b0);
    n_chk++; if (validVector_o !== 32'h00000020) begin n_err++; $display("FAIL same_valid got=%h exp=00000020", validVector_o); end
    n_chk++; if (count_o !== 6'd1) begin n_err++; $display("FAIL same_count got=%0d exp=1", count_o); end
    n_chk++; if (error_o !== 1'b0) begin n_err++; $display("FAIL same_error got=%b exp=0", error_o); end
  endtask

  task automatic test_fill();
    step(1'b1, 1'b0);
    for (int c = 0; c < 8; c++) begin
      for (int p = 0; p < AW; p++) begin a_v[p] = 1; a_i[p] = 4*c + p; end
      step(1'b0, 1'b0);
    end
    n_chk++; if (full_o !== 1'b1 || count_o !== 6'd32) begin n_err++; $display("FAIL fill_full full=%b count=%0d exp full=1 count=32", full_o, count_o); end
    n_chk++; if (validVector_o !== 32'hFFFFFFFF || error_o !== 1'b0) begin n_err++; $display("FAIL fill_valid got=%h err=%b exp=ffffffff err=0", validVector_o, error_o); end
    for (int p = 0; p < FW; p++) begin f_v[p] = 1; f_i[p] = 10 + 3*p; end
    step(1'b0, 1'b0);
    n_chk++; if (count_o !== 6'd28 || full_o !== 1'b0) begin n_err++; $display("FAIL release_count count=%0d full=%b exp count=28 full=0", count_o, full_o); end
    n_chk++; if (validVector_o !== 32'hFFF6DBFF) begin n_err++; $display("FAIL release_valid got=%h exp=fff6dbff", validVector_o); end
  endtask

  task automatic test_error_sticky();
    step(1'b1, 1'b0);
    a_v[0] = 1; a_i[0] = 3;
    step(1'b0, 1'b0);
    n_chk++; if (error_o !== 1'b0) begin n_err++; $display("FAIL sticky_pre got=%b exp=0", error_o); end
    a_v[2] = 1; a_i[2] = 3;
    step(1'b0, 1'b0);
    n_chk++; if (error_o !== 1'b1) begin n_err++; $display("FAIL sticky_set got=%b exp=1", error_o); end
    step(1'b0, 1'b1);
    n_chk++; if (error_o !== 1'b1 || validVector_o !== '0) begin n_err++; $display("FAIL sticky_flush err=%b valid=%h exp err=1 valid=0", error_o, validVector_o); end
    step(1'b0, 1'b0);
    n_chk++; if (error_o !== 1'b1) begin n_err++; $display("FAIL sticky_idle got=%b exp=1", error_o); end
    step(1'b1, 1'b0);
    n_chk++; if (error_o !== 1'b0) begin n_err++; $display("FAIL sticky_reset got=%b exp=0", error_o); end
  endtask

  task automatic test_flush();
    step(1'b1, 1'b0);
    for (int c = 0; c < 2; c++) begin
      for (int p = 0; p < AW; p++) begin a_v[p] = 1; a_i[p] = 4*c + p; end
      step(1'b0, 1'b0);
    end
    n_chk++; if (validVector_o !== 32'h000000FF) begin n_err++; $display("FAIL flush_pre got=%h exp=000000ff", validVector_o); end
    a_v[1] = 1; a_i[1] = 9;
    step(1'b0, 1'b1);
    n_chk++; if (validVector_o !== '0 || allocMask_o !== '0) begin n_err++; $display("FAIL flush_clear valid=%h mask=%h exp 0 0", validVector_o, allocMask_o); end
    n_chk++; if (empty_o !== 1'b1 || count_o !== '0 || error_o !== 1'b0) begin n_err++; $display("FAIL flush_flags empty=%b count=%0d err=%b exp 1 0 0", empty_o, count_o, error_o); end
  endtask

  task automatic test_dup_free();
    step(1'b1, 1'b0);
    a_v[0] = 1; a_i[0] = 12; a_v[3] = 1; a_i[3] = 13;
    step(1'b0, 1'b0);
    f_v[0] = 1; f_i[0] = 12; f_v[1] = 1; f_i[1] = 12;
    step(1'b0, 1'b0);
    n_chk++; if (error_o !== 1'b1) begin n_err++; $display("FAIL dup_error got=%b exp=1", error_o); end
    n_chk++; if (validVector_o !== 32'h00002000 || count_o !== 6'd1) begin n_err++; $display("FAIL dup_valid valid=%h count=%0d exp 00002000 1", validVector_o, count_o); end
  endtask

  task automatic test_random();
    bit rst, fl;
    step(1'b1, 1'b0);
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) < 4);
      fl  = ($urandom_range(0, 99) < 4);
      // mostly legal traffic, with occasional deliberate violations
      for (int p = 0; p < AW; p++) begin
        a_i[p] = $urandom_range(0, D-1);
        a_v[p] = ($urandom_range(0, 1) == 1) && (!m_occ[a_i[p]] || $urandom_range(0, 19) == 0);
      end
      for (int p = 0; p < FW; p++) begin
        f_i[p] = $urandom_range(0, D-1);
        f_v[p] = ($urandom_range(0, 1) == 1) && (m_occ[f_i[p]] || $urandom_range(0, 19) == 0);
      end
      step(rst, fl);
      n_chk++;
      if (validVector_o !== m_vec() || allocMask_o !== m_mvec() || count_o !== 6'(m_cnt())
          || error_o !== m_err || full_o !== (m_cnt() == D) || empty_o !== (m_cnt() == 0)) begin
        n_err++;
        $display("FAIL rand_%0d valid=%h/%h mask=%h/%h count=%0d/%0d err=%b/%b full=%b empty=%b (got/exp)",
                 n, validVector_o, m_vec(), allocMask_o, m_mvec(), count_o, m_cnt(), error_o, m_err, full_o, empty_o);
      end
    end
  endtask

  initial begin
    reset = 1'b1; flush_i = 1'b0;
    allocValid_i = '0; allocIdx_i = '0; freeValid_i = '0; freeIdx_i = '0;
    for (int p = 0; p < AW; p++) begin a_v[p] = 1'b0; a_i[p] = 0; end
    for (int p = 0; p < FW; p++) begin f_v[p] = 1'b0; f_i[p] = 0; end
    for (int e = 0; e < D; e++) begin m_occ[e] = 1'b0; m_mask[e] = 1'b0; end
    m_err = 1'b0;
    @(negedge clk);
    test_reset();
    test_alloc_basic();
    test_alloc_free_same();
    test_fill();
    test_error_sticky();
    test_flush();
    test_dup_free();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
